// File: rtl/mult_datapath_taint_track_word.sv
// Shift-add multiplier datapath (MD, MR, running sum) with word-granular taint tracking.
// Optional MULT_DP_PRODUCT_HOLD_EN: product comes from a register captured when product_valid rises.
module mult_datapath_taint_track_word #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               productDone,
    input  logic               productDone_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic               multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               product_valid,
    output logic               product_valid_t
);
    localparam int unsigned RsW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] md_q, md_d, mr_q, mr_d;
    logic             md_t_q, md_t_d, mr_t_q, mr_t_d;
    logic [RsW-1:0]   rs_q, rs_d;
    logic             rs_t_q, rs_t_d;
    logic [WIDTH:0]   rs_hi_sum;
    logic             valid_q, valid_t_q;

    always_comb begin
        md_d   = mdld ? multiplicand : md_q;
        md_t_d = (mdld ? multiplicand_t : md_t_q) | mdld_t;
        mr_d   = mrld ? multiplier : mr_q;
        mr_t_d = (mrld ? multiplier_t : mr_t_q) | mrld_t;
    end

    always_comb begin
        rs_hi_sum = rs_q[2*WIDTH:WIDTH] + {1'b0, md_q};
        rs_d      = rs_q;
        if (rsclear) begin
            rs_d = '0;
        end else if (rsload) begin
            rs_d = {rs_hi_sum, rs_q[WIDTH-1:0]};
        end else if (rsshr) begin
            rs_d = {1'b0, rs_q[RsW-1:1]};
        end
    end

    // A tainted strobe taints RS regardless of its value; only a clean clear scrubs it.
    always_comb begin
        if (rsclear && !rsclear_t) begin
            rs_t_d = 1'b0;
        end else begin
            rs_t_d = rs_t_q | rsclear_t | rsload_t | (rsload & md_t_q) | rsshr_t;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            md_q      <= '0;
            md_t_q    <= 1'b0;
            mr_q      <= '0;
            mr_t_q    <= 1'b0;
            rs_q      <= '0;
            rs_t_q    <= 1'b0;
            valid_q   <= 1'b0;
            valid_t_q <= 1'b0;
        end else begin
            md_q      <= md_d;
            md_t_q    <= md_t_d;
            mr_q      <= mr_d;
            mr_t_q    <= mr_t_d;
            rs_q      <= rs_d;
            rs_t_q    <= rs_t_d;
            valid_q   <= productDone;
            valid_t_q <= productDone_t;
        end
    end

`ifdef MULT_DP_PRODUCT_HOLD_EN
    logic [2*WIDTH-1:0] prod_hold_q;
    logic               prod_hold_t_q;
    logic               capture;

    // Capture the post-final-shift sum on the same edge that raises product_valid.
    assign capture = productDone & ~valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_hold_q   <= '0;
            prod_hold_t_q <= 1'b0;
        end else if (capture) begin
            prod_hold_q   <= rs_d[2*WIDTH-1:0];
            prod_hold_t_q <= rs_t_d;
        end
    end

    assign product   = prod_hold_q;
    assign product_t = prod_hold_t_q;
    logic unused_rs_msb;
    assign unused_rs_msb = rs_q[RsW-1];
`else
    assign product   = rs_q[2*WIDTH-1:0];
    assign product_t = rs_t_q;
    logic unused_rs_msb;
    assign unused_rs_msb = rs_q[RsW-1];
`endif

    assign multiplierReg   = mr_q;
    assign multiplierReg_t = mr_t_q;
    assign product_valid   = valid_q;
    assign product_valid_t = valid_t_q;

endmodule

// File: tb/tb_mult_datapath_taint_track_word.sv
// Scoreboard bench for mult_datapath_taint_track_word: plays the control-FSM strobe
// sequence, pushes the expected product/taint and compares when product_valid shows up.
module tb_mult_datapath_taint_track_word;
    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] multiplicand, multiplier;
    logic             multiplicand_t, multiplier_t;
    logic             rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t;
    logic             mrld, mrld_t, mdld, mdld_t, productDone, productDone_t;
    logic [WIDTH-1:0] multiplierReg;
    logic             multiplierReg_t;
    logic [7:0]       product;
    logic             product_t, product_valid, product_valid_t;

    typedef struct packed {
        logic [7:0] p;
        logic       t;
    } exp_t;

    exp_t       sb_q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] last_prod;
    logic       last_t;

    always #5 clk = ~clk;

    mult_datapath_taint_track_word #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .multiplicand   (multiplicand),
        .multiplicand_t (multiplicand_t),
        .multiplier     (multiplier),
        .multiplier_t   (multiplier_t),
        .rsload         (rsload),
        .rsload_t       (rsload_t),
        .rsclear        (rsclear),
        .rsclear_t      (rsclear_t),
        .rsshr          (rsshr),
        .rsshr_t        (rsshr_t),
        .mrld           (mrld),
        .mrld_t         (mrld_t),
        .mdld           (mdld),
        .mdld_t         (mdld_t),
        .productDone    (productDone),
        .productDone_t  (productDone_t),
        .multiplierReg  (multiplierReg),
        .multiplierReg_t(multiplierReg_t),
        .product        (product),
        .product_t      (product_t),
        .product_valid  (product_valid),
        .product_valid_t(product_valid_t)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        rsload = 0; rsload_t = 0; rsclear = 0; rsclear_t = 0; rsshr = 0; rsshr_t = 0;
        mrld = 0; mrld_t = 0; mdld = 0; mdld_t = 0; productDone = 0; productDone_t = 0;
    endtask

    // Full FSM sequence; lt taints every rsload step whether or not the load fires.
    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic a_t,
                       input logic lt);
        exp_t e;
        multiplicand = a; multiplier = b; multiplicand_t = a_t; multiplier_t = 0;
        mdld = 1; mrld = 1; rsclear = 1;
        tick();
        idle_strobes();
        check_eq("mr_reg", {28'd0, multiplierReg}, {28'd0, b});
        check_eq("mr_reg_t", {31'd0, multiplierReg_t}, 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            rsshr = 1;
            tick();
            rsshr = 0;
`ifdef MULT_DP_PRODUCT_HOLD_EN
            if (i == 0) begin
                check_eq("hold_prod", {24'd0, product}, {24'd0, last_prod});
                check_eq("hold_prod_t", {31'd0, product_t}, {31'd0, last_t});
            end
`endif
            rsload = b[i]; rsload_t = lt;
            tick();
            rsload = 0; rsload_t = 0;
        end
        e.p = 8'(a) * 8'(b);
        e.t = lt | (a_t & (b != 4'd0));
        sb_q.push_back(e);
        rsshr = 1; productDone = 1;
        tick();
        idle_strobes();
        tick();
        last_prod = e.p;
        last_t    = e.t;
    endtask

    always @(negedge clk) begin
        if (product_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", {31'd0, product_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("product", {24'd0, product}, {24'd0, e.p});
                check_eq("product_t", {31'd0, product_t}, {31'd0, e.t});
                check_eq("valid_t", {31'd0, product_valid_t}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_strobes();
        multiplicand = 0; multiplier = 0; multiplicand_t = 0; multiplier_t = 0;
        last_prod = 0; last_t = 0;
        rst = 0;
        tick();
        tick();
        check_eq("rst_product", {24'd0, product}, 32'd0);
        check_eq("rst_product_t", {31'd0, product_t}, 32'd0);
        check_eq("rst_valid", {31'd0, product_valid}, 32'd0);
        check_eq("rst_valid_t", {31'd0, product_valid_t}, 32'd0);
        check_eq("rst_mr", {28'd0, multiplierReg}, 32'd0);
        check_eq("rst_mr_t", {31'd0, multiplierReg_t}, 32'd0);
        rst = 1;
        tick();

        run(4'd13, 4'd11, 1'b0, 1'b0);
        run(4'd2, 4'd3, 1'b0, 1'b0);
        run(4'd15, 4'd15, 1'b0, 1'b0);
        run(4'd0, 4'd9, 1'b0, 1'b0);
        run(4'd3, 4'd0, 1'b1, 1'b0);
        run(4'd3, 4'd1, 1'b1, 1'b0);
        run(4'd0, 4'd0, 1'b0, 1'b1);
        run(4'd5, 4'd5, 1'b0, 1'b0);

        // Reset in the middle of a 13x11 run.
        multiplicand = 13; multiplier = 11; mdld = 1; mrld = 1; rsclear = 1;
        multiplierReg_t_dummy_taint();
        tick();
        idle_strobes();
        rsshr = 1; tick(); rsshr = 0;
        rsload = 1; tick(); rsload = 0;
        rsshr = 1; rst = 0;
        tick();
        rsshr = 0; rst = 1;
        check_eq("mid_rst_product", {24'd0, product}, 32'd0);
        check_eq("mid_rst_product_t", {31'd0, product_t}, 32'd0);
        check_eq("mid_rst_mr", {28'd0, multiplierReg}, 32'd0);
        check_eq("mid_rst_mr_t", {31'd0, multiplierReg_t}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, product_valid}, 32'd0);
        last_prod = 0; last_t = 0;
        tick();
        run(4'd6, 4'd7, 1'b0, 1'b0);

        tick();
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Taints the MR load in the aborted run so reset must also scrub mr_t.
    task automatic multiplierReg_t_dummy_taint();
        multiplier_t = 1;
    endtask

endmodule

// File: doc/mult_datapath_taint_track_word.md
Name: mult_datapath_taint_track_word

Overview:
- Datapath of the sequential shift-add multiplier, with word-granular taint tracking.
- Sits directly downstream of the multiplier control FSM.
  - Consumes the control FSM's rsload/rsclear/rsshr/mrld/mdld strobes and their taint bits.
  - Returns the multiplier register, plus taint, for the FSM's per-bit decisions.
- Holds the multiplicand (MD), the multiplier (MR) and a (2*WIDTH+1)-bit running sum (RS).
- Produces the 2*WIDTH-bit product, its taint and a registered valid flag.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- multiplicand  in  WIDTH  operand A, sampled on mdld.
- multiplicand_t  in  1  taint of operand A.
- multiplier  in  WIDTH  operand B, sampled on mrld.
- multiplier_t  in  1  taint of operand B.
- rsload, rsload_t  in  1,1  add MD into RS upper part / taint.
- rsclear, rsclear_t  in  1,1  clear RS / taint.
- rsshr, rsshr_t  in  1,1  shift RS right by 1 / taint.
- mrld, mrld_t  in  1,1  load MR / taint.
- mdld, mdld_t  in  1,1  load MD / taint.
- productDone, productDone_t  in  1,1  FSM final-state flag / taint.
- multiplierReg  out  WIDTH  MR register contents to the control FSM.
- multiplierReg_t  out  1  MR taint.
- product  out  2*WIDTH  multiplication result.
- product_t  out  1  product taint.
- product_valid  out  1  registered: high the cycle after productDone.
- product_valid_t  out  1  taint of product_valid.

Behaviour:
- Reset (rst==0 at rising edge), including mid-operation:
  - MD, MR, RS, all taint registers, product_valid and product_valid_t go to 0 on that edge.
  - All outputs read 0 from the next cycle.
- MD register:
  - If mdld: MD <= multiplicand.
  - md_t <= (mdld ? multiplicand_t : md_t) | mdld_t.
- MR register: identical rule using mrld, multiplier, multiplier_t and mrld_t.
  - multiplierReg = MR; multiplierReg_t = mr_t.
- RS value update, priority rsclear > rsload > rsshr; hold if none.
  - rsclear: RS <= 0.
  - rsload: RS[2W:W] <= RS[2W:W] + {1'b0, MD}, a (W+1)-bit add; RS[W-1:0] unchanged; no overflow is possible.
  - rsshr: RS <= {1'b0, RS[2W:1]}.
  - The FSM never asserts two RS strobes together; the priority exists for robustness only.
- RS taint (constant-time model: a tainted strobe taints the register whether the strobe is 0 or 1):
  - If rsclear & !rsclear_t: rs_t <= 0.
  - Otherwise: rs_t <= rs_t | rsclear_t | (rsload_t | (rsload & md_t)) | rsshr_t.
- Expected FSM sequence: INIT (mdld, mrld, rsclear), then WIDTH × (rsshr; conditional rsload of MR bit i), then final rsshr with productDone.
  - This yields RS[2W-1:0] = MD*MR after the final shift edge.
- Product: product = RS[2W-1:0]; product_t = rs_t.
- product_valid <= productDone; product_valid_t <= productDone_t.
  - product is final in the cycle where product_valid==1.
- Total latency from the INIT cycle to product_valid: 2*WIDTH+2 cycles.
- A new INIT (rsclear) while product_valid is high is legal.
  - product changes on the following edge; product_valid drops unless productDone is still asserted.
- Taint is never cleared except by reset or an untainted rsclear.
  - A tainted MD or MR persists across multiplications until reloaded by an untainted load of an untainted operand.

Optional Feature:
- Macro: MULT_DP_PRODUCT_HOLD_EN.
- Defined:
  - product and product_t come from a dedicated 2*WIDTH+1-bit register, captured from RS/rs_t on the edge where product_valid rises.
  - The register holds until the next capture or reset, so product stays stable through the following multiplication.
- Undefined:
  - product and product_t are combinational from RS/rs_t as above.
  - No extra registers.

Test Plan:
- WIDTH=4, drive the FSM sequence with MD=13, MR=11, all taints 0 -> product_valid=1, product=8'h8F (143), product_t=0.
- MD=15, MR=15 -> product=8'hE1 (225) with RS[8] carry exercised mid-run; MD=0, MR=9 -> product=0.
- multiplicand_t=1 with MD=3, MR=0 (no rsload ever asserted) -> product=0, product_t=0; repeat with MR=1 -> product_t=1.
- rsload_t=1 on every odd step, all data taints 0, MR=0 -> product=0, product_t=1; next run with untainted rsclear -> product_t=0.
- Assert rst=0 for one cycle midway through a 13×11 run -> all registers and outputs 0 next cycle; a fresh 6×7 run then gives product=8'h2A.
- With MULT_DP_PRODUCT_HOLD_EN: after 13×11 completes, start 2×3 -> product holds 8'h8F until the 2×3 product_valid, then shows 8'h06.
